// File: rtl/rvc_asap_pkg.sv
// rvc_asap_pkg: shared CR region constants and address decode helper
package rvc_asap_pkg;
    localparam logic [1:0]  CR_MEM_REGION = 2'b10;
    localparam logic [11:0] CR_SEG7_BASE  = 12'h000;
    localparam logic [11:0] CR_LED        = 12'h020;
    localparam logic [11:0] CR_BTN_LVL    = 12'h024;
    localparam logic [11:0] CR_BTN_EVT    = 12'h028;
    localparam logic [11:0] CR_SWITCH     = 12'h02C;
    localparam logic [11:0] CR_IRQ_MASK   = 12'h030;
    typedef logic [31:0] t_cr_word;
    function automatic logic cr_hit(input logic [31:0] addr);
        return addr[13:12] == CR_MEM_REGION && addr[1:0] == 2'b00;
    endfunction
endpackage

// File: rtl/rvc_asap_debounce.sv
// rvc_asap_debounce: 2-flop synchroniser plus counter debounce for one button, with rise pulse
module rvc_asap_debounce #(
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic Clock,
    input  logic Rst,
    input  logic raw,
    output logic level,
    output logic rise
);
    localparam int CW = $clog2(DEBOUNCE_CYC + 1);
    logic s1, s2, done;
    logic [CW-1:0] cnt;
    assign done = s2 != level && cnt == CW'(DEBOUNCE_CYC - 1);
    assign rise = done && !level;
    always_ff @(posedge Clock) begin
        if (Rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            cnt   <= (s2 == level || done) ? '0 : cnt + CW'(1);
            level <= level ^ done;
        end
    end
endmodule

// File: rtl/rvc_asap_cr_ctrl.sv
// rvc_asap_cr_ctrl: CR region registers (seg7, LED, buttons with events/irq, switches)
module rvc_asap_cr_ctrl
    import rvc_asap_pkg::*;
#(
    parameter int N_SEG7       = 6,
    parameter int LED_W        = 10,
    parameter int N_BTN        = 2,
    parameter int SW_W         = 10,
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic                  Clock,
    input  logic                  Rst,
    input  logic                  RdEn,
    input  logic                  WrEn,
    input  logic [31:0]           Addr,
    input  logic [31:0]           WrData,
    output logic [31:0]           RdData,
    input  logic [N_BTN-1:0]      Button,
    input  logic [SW_W-1:0]       Switch,
    output logic [7*N_SEG7-1:0]   Seg7,
    output logic [LED_W-1:0]      Led,
    output logic                  CrIrq
);
    typedef logic [6:0]       t_seg7;
    typedef logic [N_BTN-1:0] t_btn;
    t_seg7 [N_SEG7-1:0] seg;
    logic [LED_W-1:0] led;
    t_btn lvl, rise, evt, mask, w1c;
    logic [SW_W-1:0] sw_s1, sw_s2;
    t_cr_word rd_nxt;
    logic [11:0] off;
    logic hit, unused_ok;
    assign hit       = cr_hit(Addr);
    assign off       = Addr[11:0];
    assign unused_ok = ^{Addr[31:14], WrData};
    assign w1c       = (WrEn && hit && off == CR_BTN_EVT) ? WrData[N_BTN-1:0] : '0;
    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        rvc_asap_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
            .Clock (Clock),
            .Rst   (Rst),
            .raw   (Button[i]),
            .level (lvl[i]),
            .rise  (rise[i])
        );
    end
    always_comb begin
        rd_nxt = off == CR_LED      ? 32'(led)   :
                 off == CR_BTN_LVL  ? 32'(lvl)   :
                 off == CR_BTN_EVT  ? 32'(evt)   :
                 off == CR_SWITCH   ? 32'(sw_s2) :
                 off == CR_IRQ_MASK ? 32'(mask)  : '0;
        for (int k = 0; k < N_SEG7; k++)
            if (off == CR_SEG7_BASE + 12'(4 * k)) rd_nxt = 32'(seg[k]);
    end
    always_ff @(posedge Clock) begin
        if (Rst) begin
            RdData <= '0;
            seg    <= '0;
            led    <= '0;
            evt    <= '0;
            mask   <= '0;
            sw_s1  <= '0;
            sw_s2  <= '0;
        end else begin
            if (RdEn && hit) RdData <= rd_nxt;
            if (WrEn && hit) begin
                for (int k = 0; k < N_SEG7; k++)
                    if (off == CR_SEG7_BASE + 12'(4 * k)) seg[k] <= WrData[6:0];
                if (off == CR_LED) led <= WrData[LED_W-1:0];
                if (off == CR_IRQ_MASK) mask <= WrData[N_BTN-1:0];
            end
            // a rise on the same edge as a W1C clear wins
            evt   <= (evt & ~w1c) | rise;
            sw_s1 <= Switch;
            sw_s2 <= sw_s1;
        end
    end
    assign Seg7  = seg;
    assign Led   = led;
    assign CrIrq = |(evt & mask);
endmodule

// File: tb/tb_rvc_asap_cr_ctrl.sv
// tb_rvc_asap_cr_ctrl: randomized bench against a history-window reference model
module tb_rvc_asap_cr_ctrl;
    localparam int NS = 6, LW = 10, NB = 2, SW = 10, DC = 16;
    logic Clock = 1'b0;
    logic Rst, RdEn, WrEn, CrIrq;
    logic [31:0] Addr, WrData, RdData;
    logic [NB-1:0] Button;
    logic [SW-1:0] Switch;
    logic [7*NS-1:0] Seg7;
    logic [LW-1:0] Led;
    int n_vec = 0, n_bad = 0;
    always #5 Clock = ~Clock;
    rvc_asap_cr_ctrl #(.N_SEG7(NS), .LED_W(LW), .N_BTN(NB), .SW_W(SW), .DEBOUNCE_CYC(DC)) dut (
        .Clock(Clock), .Rst(Rst), .RdEn(RdEn), .WrEn(WrEn), .Addr(Addr), .WrData(WrData),
        .RdData(RdData), .Button(Button), .Switch(Switch), .Seg7(Seg7), .Led(Led), .CrIrq(CrIrq)
    );
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask
    logic [6:0] m_seg[NS];
    logic [LW-1:0] m_led;
    logic [NB-1:0] m_lvl, m_evt, m_mask;
    logic [31:0] m_rd;
    logic [NB-1:0] bh[$], sh[$];
    logic [SW-1:0] swh[$];
    logic [NB-1:0] s_cur, f_cur, w1c_m;
    logic [11:0] off_m;
    bit hit_m;
    // raw input seen two edges ago is what the synchroniser presents now
    function automatic logic [NB-1:0] sync_now();
        return bh.size() >= 2 ? bh[bh.size()-2] : '0;
    endfunction
    // a level flips once DC consecutive synchronised samples disagree with it
    function automatic logic [NB-1:0] flips(input logic [NB-1:0] s);
        logic [NB-1:0] f = '0;
        for (int i = 0; i < NB; i++) begin
            bit ok = (s[i] != m_lvl[i]) && (sh.size() >= DC - 1);
            for (int j = 1; j < DC && ok; j++)
                if (sh[sh.size()-j][i] == m_lvl[i]) ok = 0;
            f[i] = ok;
        end
        return f;
    endfunction
    function automatic logic [31:0] rd_model(input logic [11:0] off);
        int k = int'(off[4:2]);
        logic [SW-1:0] sw2 = swh.size() >= 2 ? swh[swh.size()-2] : '0;
        if (off[11:5] == 0) return k < NS ? 32'(m_seg[k]) : 32'h0;
        case (off)
            12'h020: return 32'(m_led);
            12'h024: return 32'(m_lvl);
            12'h028: return 32'(m_evt);
            12'h02C: return 32'(sw2);
            12'h030: return 32'(m_mask);
            default: return 32'h0;
        endcase
    endfunction
    always @(posedge Clock) begin
        if (Rst) begin
            for (int k = 0; k < NS; k++) m_seg[k] = '0;
            m_led = '0; m_lvl = '0; m_evt = '0; m_mask = '0; m_rd = '0;
            bh.delete(); sh.delete(); swh.delete();
        end else begin
            off_m = Addr[11:0];
            hit_m = Addr[13:12] == 2'b10 && Addr[1:0] == 2'b00;
            s_cur = sync_now();
            f_cur = flips(s_cur);
            if (RdEn && hit_m) m_rd = rd_model(off_m);
            w1c_m = '0;
            if (WrEn && hit_m) begin
                if (off_m[11:5] == 0 && int'(off_m[4:2]) < NS) m_seg[off_m[4:2]] = WrData[6:0];
                if (off_m == 12'h020) m_led = WrData[LW-1:0];
                if (off_m == 12'h030) m_mask = WrData[NB-1:0];
                if (off_m == 12'h028) w1c_m = WrData[NB-1:0];
            end
            m_evt = (m_evt & ~w1c_m) | (f_cur & ~m_lvl);
            m_lvl = m_lvl ^ f_cur;
            sh.push_back(s_cur); bh.push_back(Button); swh.push_back(Switch);
            if (sh.size() > 40) begin sh.pop_front(); bh.pop_front(); swh.pop_front(); end
        end
    end
    function automatic logic [7*NS-1:0] seg_exp();
        logic [7*NS-1:0] e;
        for (int k = 0; k < NS; k++) e[7*k +: 7] = m_seg[k];
        return e;
    endfunction
    initial begin
        int r;
        Rst = 1'b1; RdEn = 1'b0; WrEn = 1'b0; Addr = '0; WrData = '0; Button = '0; Switch = '0;
        for (int cyc = 0; cyc < 5000; cyc++) begin
            @(negedge Clock);
            check("rd_data", 64'(RdData), 64'(m_rd));
            check("seg7", 64'(Seg7), 64'(seg_exp()));
            check("led", 64'(Led), 64'(m_led));
            check("cr_irq", 64'(CrIrq), 64'(|(m_evt & m_mask)));
            if (cyc < 2) continue;
            if (cyc < 17) begin
                Rst = 1'b0; RdEn = 1'b1; WrEn = 1'b0;
                Addr = cyc < 16 ? 32'h2000 + 32'(4 * (cyc - 2)) : 32'h2040;
                continue;
            end
            Rst = ($urandom % 700) == 0;
            for (int i = 0; i < NB; i++) if ($urandom % 20 == 0) Button[i] = ~Button[i];
            if ($urandom % 40 == 0) Switch = SW'($urandom);
            RdEn = $urandom % 2 == 0;
            WrEn = $urandom % 3 == 0;
            r = $urandom_range(0, 15);
            Addr = r < 14 ? 32'h2000 + 32'(4 * r) : r == 14 ? 32'h2040 : ($urandom % 2 ? 32'h1020 : 32'h2022);
            WrData = $urandom;
            if (!Rst && |(flips(sync_now()) & ~m_lvl) && $urandom % 2 == 0) begin
                WrEn = 1'b1; Addr = 32'h2028; WrData = '1;
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
